// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, the 4:4:4 pixel colour type and the test-bar palette.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Element 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][11:0] BAR_COLOURS = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        return rgb_t'(BAR_COLOURS[idx]);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// DEPTH x WIDTH shift register with asynchronous active-low clear; DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk;
        assign unused_clk = clk ^ rst_n;
        assign dout       = din;
    end else begin : g_shift
        logic [DEPTH-1:0][WIDTH-1:0] stage;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage <= '0;
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: request-stage coordinates plus PIPE_LAT-aligned sync and RGB pins.
// Define VGA_TEST_PATTERN_EN to add the test_mode input and the eight-bar colour generator.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    output logic        frame_start,
    input  logic [11:0] rgb_in,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_timing
        $error("vga_timing_gen: timing sums exceed the 10-bit counter range");
    end
    if (PIPE_LAT > 8) begin : g_bad_latency
        $error("vga_timing_gen: PIPE_LAT must be 0..8");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hcnt, vcnt;
    logic       hs_raw, vs_raw;
    logic       hs_d, vs_d, act_d;
    rgb_t       rgb_q, rgb_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    assign pix_x       = hcnt;
    assign pix_y       = vcnt;
    assign pix_req     = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign frame_start = (hcnt == '0) && (vcnt == '0);
    assign hs_raw      = (hcnt >= HS_START) && (hcnt < HS_END);
    assign vs_raw      = (vcnt >= VS_START) && (vcnt < VS_END);

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned DL_W = 13;
    localparam logic [9:0]  BAR_W = 10'(H_ACTIVE / 8);
    logic [9:0]      hcnt_d;
    logic [2:0]      bar_idx;
    logic [DL_W-1:0] dl_in, dl_out;

    assign dl_in                          = {hcnt, hs_raw, vs_raw, pix_req};
    assign {hcnt_d, hs_d, vs_d, act_d}    = dl_out;
    assign bar_idx                        = 3'(hcnt_d / BAR_W);
`else
    localparam int unsigned DL_W = 3;
    logic [DL_W-1:0] dl_in, dl_out;

    assign dl_in               = {hs_raw, vs_raw, pix_req};
    assign {hs_d, vs_d, act_d} = dl_out;
`endif

    vga_delay_line #(
        .DEPTH (PIPE_LAT),
        .WIDTH (DL_W)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (dl_in),
        .dout  (dl_out)
    );

    // Blanking wins over whatever the renderer drives outside the active area
    always_comb begin
        rgb_next = '0;
        if (act_d) begin
`ifdef VGA_TEST_PATTERN_EN
            rgb_next = test_mode ? bar_colour(bar_idx) : rgb_t'(rgb_in);
`else
            rgb_next = rgb_t'(rgb_in);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            rgb_q <= '0;
        end else begin
            hsync <= hs_d ^ ~SYNC_POL;
            vsync <= vs_d ^ ~SYNC_POL;
            rgb_q <= rgb_next;
        end
    end

    assign vga_r = rgb_q.r;
    assign vga_g = rgb_q.g;
    assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised self-checking bench for vga_timing_gen against an arithmetic raster model.
// Vertical timing is shortened so whole frames fit in a short run; horizontal timing is stock.
module tb_vga_timing_gen;

    localparam int H_ACT = 640;
    localparam int H_FP  = 16;
    localparam int H_SY  = 96;
    localparam int H_BP  = 48;
    localparam int V_ACT = 12;
    localparam int V_FP  = 2;
    localparam int V_SY  = 2;
    localparam int V_BP  = 3;
    localparam int LAT   = 2;
    localparam bit SPOL  = 1'b0;
    localparam int L     = LAT + 1;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int M_COORD = 0;
    localparam int M_RAND  = 1;
    localparam int M_WHITE = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pix_x, pix_y;
    logic        pix_req, frame_start;
    logic [11:0] rgb_in;
    logic        hsync, vsync;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [11:0] rgb_pins;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_mode;
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          k;
    int          mode;
    logic [11:0] rgb_last;
    logic [19:0] req_q [$];

    assign rgb_pins = {vga_r, vga_g, vga_b};

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
        .SYNC_POL (SPOL), .PIPE_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_req     (pix_req),
        .frame_start (frame_start),
        .rgb_in      (rgb_in),
        .hsync       (hsync),
        .vsync       (vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    // Raster model: kk is the number of clock edges since reset release
    function automatic int req_h(int kk);
        return kk % H_TOT;
    endfunction

    function automatic int req_v(int kk);
        return (kk / H_TOT) % V_TOT;
    endfunction

    function automatic bit active_at(int kk);
        return (req_h(kk) < H_ACT) && (req_v(kk) < V_ACT);
    endfunction

    function automatic bit pin_active(int kk);
        return (kk >= L) && active_at(kk - L);
    endfunction

    function automatic logic exp_hsync(int kk);
        bit on = 1'b0;
        if (kk >= L) on = (req_h(kk - L) >= H_ACT + H_FP) && (req_h(kk - L) < H_ACT + H_FP + H_SY);
        return on ? SPOL : !SPOL;
    endfunction

    function automatic logic exp_vsync(int kk);
        bit on = 1'b0;
        if (kk >= L) on = (req_v(kk - L) >= V_ACT + V_FP) && (req_v(kk - L) < V_ACT + V_FP + V_SY);
        return on ? SPOL : !SPOL;
    endfunction

    function automatic logic [11:0] exp_coord_rgb(int kk);
        logic [9:0] hh, vv;
        if (!pin_active(kk)) return 12'h000;
        hh = 10'(req_h(kk - L));
        vv = 10'(req_v(kk - L));
        return {hh[3:0], vv[3:0], 4'hA};
    endfunction

    // Renderer model: answers each DUT request LAT cycles later, then advances one clock
    task automatic cycle();
        logic [19:0] e = '0;
        bit          have = 1'b0;
        logic [11:0] nxt = 12'h000;
        req_q.push_back({pix_x, pix_y});
        if (req_q.size() > LAT) begin
            e    = req_q.pop_front();
            have = 1'b1;
        end
        case (mode)
            M_COORD: if (have) nxt = {e[13:10], e[3:0], 4'hA};
            M_RAND:  nxt = 12'($urandom);
            default: nxt = 12'hFFF;
        endcase
        rgb_last = nxt;
        rgb_in   = nxt;
        @(negedge clk);
        k++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks += 4;
            if (hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync cyc=%0d got %b want 1", i, hsync); end
            if (vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync cyc=%0d got %b want 1", i, vsync); end
            if (rgb_pins !== 12'h000) begin n_fail++; $display("FAIL reset_rgb cyc=%0d got %h want 000", i, rgb_pins); end
            if (pix_req !== 1'b1 || frame_start !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_req cyc=%0d got req=%b fs=%b want 1 1", i, pix_req, frame_start);
            end
        end
        rst_n    = 1'b1;
        k        = 0;
        rgb_last = 12'h000;
        req_q.delete();
        #1;
        n_checks += 2;
        if (pix_x !== 10'd0 || pix_y !== 10'd0) begin
            n_fail++; $display("FAIL release_xy got (%0d,%0d) want (0,0)", pix_x, pix_y);
        end
        if (pix_req !== 1'b1 || frame_start !== 1'b1) begin
            n_fail++; $display("FAIL release_req got req=%b fs=%b want 1 1", pix_req, frame_start);
        end
    endtask

    task automatic test_frame();
        int   errs = 0;
        int   h_fall1 = -1, h_fall2 = -1, h_low = 0;
        int   v_falls = 0, v_low = 0;
        int   fs_cnt = 0, fs1 = -1, fs2 = -1;
        logic prev_h = 1'b1, prev_v = 1'b1;
        mode = M_COORD;
        for (int i = 0; i < V_TOT * H_TOT + 2 * H_TOT && errs < 20; i++) begin
            n_checks += 7;
            if (pix_x !== 10'(req_h(k))) begin errs++; n_fail++; $display("FAIL frame_pix_x k=%0d got %0d want %0d", k, pix_x, req_h(k)); end
            if (pix_y !== 10'(req_v(k))) begin errs++; n_fail++; $display("FAIL frame_pix_y k=%0d got %0d want %0d", k, pix_y, req_v(k)); end
            if (pix_req !== active_at(k)) begin errs++; n_fail++; $display("FAIL frame_pix_req k=%0d got %b want %b", k, pix_req, active_at(k)); end
            if (frame_start !== (req_h(k) == 0 && req_v(k) == 0)) begin
                errs++; n_fail++; $display("FAIL frame_start k=%0d got %b", k, frame_start);
            end
            if (hsync !== exp_hsync(k)) begin errs++; n_fail++; $display("FAIL frame_hsync k=%0d got %b want %b", k, hsync, exp_hsync(k)); end
            if (vsync !== exp_vsync(k)) begin errs++; n_fail++; $display("FAIL frame_vsync k=%0d got %b want %b", k, vsync, exp_vsync(k)); end
            if (rgb_pins !== exp_coord_rgb(k)) begin
                errs++; n_fail++; $display("FAIL align_rgb k=%0d got %h want %h", k, rgb_pins, exp_coord_rgb(k));
            end
            if (prev_h && !hsync) begin
                if (h_fall1 < 0) h_fall1 = k;
                else if (h_fall2 < 0) h_fall2 = k;
            end
            if (!hsync && h_fall1 >= 0 && h_fall2 < 0) h_low++;
            if (prev_v && !vsync) v_falls++;
            if (!vsync) v_low++;
            if (frame_start) begin
                fs_cnt++;
                if (fs1 < 0) fs1 = k;
                else if (fs2 < 0) fs2 = k;
            end
            prev_h = hsync;
            prev_v = vsync;
            cycle();
        end
        n_checks += 7;
        if (h_fall1 !== H_ACT + H_FP + L) begin n_fail++; $display("FAIL hsync_fall got %0d want %0d", h_fall1, H_ACT + H_FP + L); end
        if (h_low !== H_SY) begin n_fail++; $display("FAIL hsync_width got %0d want %0d", h_low, H_SY); end
        if (h_fall2 - h_fall1 !== H_TOT) begin n_fail++; $display("FAIL line_period got %0d want %0d", h_fall2 - h_fall1, H_TOT); end
        if (v_falls !== 1) begin n_fail++; $display("FAIL vsync_pulses got %0d want 1", v_falls); end
        if (v_low !== V_SY * H_TOT) begin n_fail++; $display("FAIL vsync_width got %0d want %0d", v_low, V_SY * H_TOT); end
        if (fs_cnt !== 2) begin n_fail++; $display("FAIL frame_start_count got %0d want 2", fs_cnt); end
        if (fs2 - fs1 !== V_TOT * H_TOT) begin n_fail++; $display("FAIL frame_period got %0d want %0d", fs2 - fs1, V_TOT * H_TOT); end
    endtask

    task automatic test_colour(input int n, input int m, input string name);
        int          errs = 0;
        logic [11:0] exp;
        mode = m;
        for (int i = 0; i < n && errs < 20; i++) begin
            exp = pin_active(k) ? rgb_last : 12'h000;
            n_checks++;
            if (rgb_pins !== exp) begin
                errs++; n_fail++; $display("FAIL %s_rgb k=%0d got %h want %h", name, k, rgb_pins, exp);
            end
            cycle();
        end
    endtask

    task automatic test_mid_reset();
        int v_t  = V_ACT + V_FP + int'($urandom_range(0, V_SY - 1));
        int h_t  = int'($urandom_range(H_ACT + H_FP + L, H_ACT + H_FP + H_SY - 1));
        int hold = int'($urandom_range(1, 4));
        int errs = 0;
        mode = M_COORD;
        for (int i = 0; i < V_TOT * H_TOT && !(req_h(k) == h_t && req_v(k) == v_t); i++) cycle();
        n_checks += 2;
        if (pix_x !== 10'(h_t) || pix_y !== 10'(v_t)) begin
            n_fail++; $display("FAIL midrst_target got (%0d,%0d) want (%0d,%0d)", pix_x, pix_y, h_t, v_t);
        end
        if (hsync !== SPOL || vsync !== SPOL) begin
            n_fail++; $display("FAIL midrst_inflight got hs=%b vs=%b want both %b", hsync, vsync, SPOL);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (hsync !== !SPOL || vsync !== !SPOL || rgb_pins !== 12'h000) begin
            n_fail++; $display("FAIL midrst_async_pins got hs=%b vs=%b rgb=%h want %b %b 000", hsync, vsync, rgb_pins, !SPOL, !SPOL);
        end
        if (pix_x !== 10'd0 || pix_y !== 10'd0) begin
            n_fail++; $display("FAIL midrst_async_xy got (%0d,%0d) want (0,0)", pix_x, pix_y);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if (hsync !== !SPOL || vsync !== !SPOL || rgb_pins !== 12'h000 || frame_start !== 1'b1) begin
                n_fail++; $display("FAIL midrst_hold cyc=%0d got hs=%b vs=%b rgb=%h fs=%b", i, hsync, vsync, rgb_pins, frame_start);
            end
        end
        rst_n    = 1'b1;
        k        = 0;
        rgb_last = 12'h000;
        req_q.delete();
        for (int i = 0; i < 2 * H_TOT && errs < 20; i++) begin
            n_checks += 4;
            if (pix_x !== 10'(req_h(k)) || pix_y !== 10'(req_v(k))) begin
                errs++; n_fail++; $display("FAIL restart_xy k=%0d got (%0d,%0d) want (%0d,%0d)", k, pix_x, pix_y, req_h(k), req_v(k));
            end
            if (hsync !== exp_hsync(k)) begin errs++; n_fail++; $display("FAIL restart_hsync k=%0d got %b want %b", k, hsync, exp_hsync(k)); end
            if (vsync !== exp_vsync(k)) begin errs++; n_fail++; $display("FAIL restart_vsync k=%0d got %b want %b", k, vsync, exp_vsync(k)); end
            if (rgb_pins !== exp_coord_rgb(k)) begin
                errs++; n_fail++; $display("FAIL restart_rgb k=%0d got %h want %h", k, rgb_pins, exp_coord_rgb(k));
            end
            cycle();
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        int          errs = 0;
        logic [11:0] exp;
        test_mode = 1'b1;
        mode      = M_RAND;
        for (int i = 0; i < 2 * H_TOT && errs < 20; i++) begin
            exp = pin_active(k) ? bars[req_h(k - L) / (H_ACT / 8)] : 12'h000;
            n_checks++;
            if (rgb_pins !== exp) begin
                errs++; n_fail++; $display("FAIL pattern_rgb k=%0d got %h want %h", k, rgb_pins, exp);
            end
            cycle();
        end
        test_mode = 1'b0;
    endtask
`endif

    initial begin
        rst_n    = 1'b1;
        rgb_in   = 12'h000;
        rgb_last = 12'h000;
        k        = 0;
        mode     = M_COORD;
`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        #1;
        test_reset();
        test_frame();
        test_colour(V_TOT * H_TOT, M_WHITE, "blank");
        test_colour(3000, M_RAND, "random");
        test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached k=%0d", k);
        $fatal(1, "watchdog expired");
    end

endmodule
